tt_mvex_lq: RTL and testbench
=============================

// Module: tt_mvex_lq
// PURPOSE
//  Load queue that consumes matrix-unit read results (mvex lq_vld/id/data, 1c stage) and writes them back to the VRF.
//  Slots are allocated in order at issue, filled out of order by LQ id, and drained strictly in order.
//  Drain uses a valid/ready handshake toward the VRF write port.
// PARAMETERS
//  LQ_DEPTH_LOG2  3    log2 of slot count (DEPTH = 2**LQ_DEPTH_LOG2)
//  VLEN           256  result data width
//  VREG_ADDR_W    5    destination vector register index width
// PORTS
//  i_clk             in   1              clock
//  i_reset_n         in   1              async active-low reset
//  i_alloc_vld       in   1              issue requests a slot
//  i_alloc_vd        in   VREG_ADDR_W    destination vreg of the allocating op
//  o_alloc_rdy       out  1              slot available (= ~o_full)
//  o_alloc_id        out  LQ_DEPTH_LOG2  id granted this cycle (tail index)
//  i_mvex_lq_vld_1c  in   1              matrix-unit result valid
//  i_mvex_lq_id_1c   in   LQ_DEPTH_LOG2  result slot id
//  i_mvex_lq_data_1c in   VLEN           result data
//  o_wb_vld          out  1              head result ready for writeback
//  i_wb_rdy          in   1              VRF accepts writeback
//  o_wb_vd           out  VREG_ADDR_W    writeback destination
//  o_wb_data         out  VLEN           writeback data
//  o_wb_id           out  LQ_DEPTH_LOG2  slot id being drained
//  i_flush           in   1              discard all slots
//  o_count           out  LQ_DEPTH_LOG2+1 occupied slots
//  o_empty / o_full  out  1              count==0 / count==DEPTH
//  o_fill_err        out  1              sticky: fill hit a slot not in ALLOC
// BEHAVIOUR
//  - Reset (async, i_reset_n=0): head=tail=0, all slots FREE, count 0, o_wb_vld 0, o_wb_* 0, o_alloc_id 0,
//    o_empty 1, o_full 0, o_alloc_rdy 1, o_fill_err 0. The data array is not reset.
//  - Pointers are LQ_DEPTH_LOG2+1 bits; the MSB distinguishes full from empty on wrap. Index = low bits.
//  - Per-slot FSM: FREE -alloc-> ALLOC -fill-> FILLED -drain-> FREE; flush forces FREE from any state.
//  - Alloc fires on i_alloc_vld & o_alloc_rdy. The slot at tail becomes ALLOC, vd is stored, and tail increments.
//    o_alloc_rdy depends only on count (no drain-to-alloc combinational path), so a full queue refuses alloc
//    even in a cycle where it drains.
//  - Fill: i_mvex_lq_vld_1c to an ALLOC slot stores the data and sets the slot FILLED on the next edge.
//    A fill to a FREE or FILLED slot is dropped and sets o_fill_err, which holds until reset.
//  - Drain: o_wb_vld = head slot FILLED. The drain fires on o_wb_vld & i_wb_rdy; the head slot goes FREE and head increments.
//    o_wb_vd/data/id are driven from the head slot and are 0 when o_wb_vld=0.
//    Once o_wb_vld is high, it and the payload stay stable until accepted (only flush can withdraw it).
//  - Alloc, fill and drain in the same cycle are all legal and independent.
//    count_next = count + alloc_fire - drain_fire.
//  - Flush has priority over alloc, fill and drain in the same cycle: all slots go FREE, head=tail=0 and count=0 on the next edge.
//    A fill arriving after flush targets a FREE slot and is dropped with o_fill_err set.
//    Upstream guarantees no in-flight fills at flush; the error flags a violation of that guarantee.
//  - Latency: fill at edge N -> o_wb_vld high after edge N (registered), unless TT_MVEX_LQ_BYPASS_EN is defined.
// CONFIGURATION
//  TT_MVEX_LQ_BYPASS_EN defined:
//   - If the head slot is ALLOC and a fill targets the head id in the same cycle, o_wb_vld=1 combinationally.
//     The payload is taken from i_mvex_lq_data_1c and the stored vd.
//   - If i_wb_rdy=1, the slot goes directly to FREE and the data is not written.
//     If i_wb_rdy=0, the slot becomes FILLED as usual.
//   - Flush still suppresses the bypass.
//  Undefined: no bypass; results always pass through the array (one cycle of extra latency).
// STRUCTURE
//  - tt_briscv_pkg gets:
//    - typedef enum logic [1:0] {LQ_FREE, LQ_ALLOC, LQ_FILLED} mvex_lq_state_e;
//    - typedef struct {vd; data} mvex_lq_entry_t.
//  - Sub-module tt_mvex_lq_ptr: wrap-around pointer with inc, clr and async reset.
//    It is instantiated twice (head and tail).
// TESTING
//  1. Alloc vd=3,4,5 (ids 0,1,2), fill id1=0xA, then id0=0xB, then id2=0xC, rdy=1.
//     -> wb order: id0/vd3/0xB, id1/vd4/0xA, id2/vd5/0xC.
//  2. Alloc 8 slots -> o_full=1, o_alloc_rdy=0, o_count=8.
//     Fill id0 and drain it while i_alloc_vld=1 -> no alloc that cycle; o_count=7 next cycle.
//  3. With o_wb_vld=1 and i_wb_rdy=0 held for 5 cycles -> payload stable.
//     rdy=1 -> exactly one drain.
//  4. After wrap (10 alloc/drain pairs) -> head=tail=2 with MSB equal, o_empty=1; o_alloc_id=2.
//  5. Flush with 3 slots FILLED plus a same-cycle alloc -> o_count=0, o_wb_vld=0.
//     A fill to id1 next cycle -> o_fill_err=1.
//  6. BYPASS_EN: alloc id0, fill id0=0x55 with rdy=1 in the same cycle -> o_wb_vld=1 that cycle, o_wb_data=0x55.
//     Without the macro -> o_wb_vld=1 one cycle later.
//  Also: assert i_reset_n mid-drain -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/tt_mvex_lq_pkg.sv
// Shared types and widths for the matrix-unit load queue.
// Contents:
//   VLEN, VREG_ADDR_W   result data width, destination vreg index width
//   mvex_lq_state_e     per-slot lifecycle state
//   mvex_lq_entry_t     per-slot payload (destination vreg + result data)
package tt_mvex_lq_pkg;

   localparam int VLEN        = 256;
   localparam int VREG_ADDR_W = 5;

   typedef enum logic [1:0] {
      LQ_FREE   = 2'd0,
      LQ_ALLOC  = 2'd1,
      LQ_FILLED = 2'd2
   } mvex_lq_state_e;

   typedef struct packed {
      logic [VREG_ADDR_W-1:0] vd;
      logic [VLEN-1:0]        data;
   } mvex_lq_entry_t;

endpackage

// File: rtl/tt_mvex_lq_if.sv
// Handshake bundle for tt_mvex_lq: the issue-side allocation port, the
// matrix-unit result (fill) port and the VRF writeback (drain) port.
//   master : issue / matrix unit / VRF side (drives alloc, fill, wb_rdy)
//   slave  : the load queue
interface tt_mvex_lq_if #(
   parameter int LQ_DEPTH_LOG2 = 3
) ();
   import tt_mvex_lq_pkg::*;

   logic                     alloc_vld;
   logic [VREG_ADDR_W-1:0]   alloc_vd;
   logic                     alloc_rdy;
   logic [LQ_DEPTH_LOG2-1:0] alloc_id;

   logic                     mvex_lq_vld_1c;
   logic [LQ_DEPTH_LOG2-1:0] mvex_lq_id_1c;
   logic [VLEN-1:0]          mvex_lq_data_1c;

   logic                     wb_vld;
   logic                     wb_rdy;
   logic [VREG_ADDR_W-1:0]   wb_vd;
   logic [VLEN-1:0]          wb_data;
   logic [LQ_DEPTH_LOG2-1:0] wb_id;

   modport master (
      output alloc_vld, alloc_vd,
      input  alloc_rdy, alloc_id,
      output mvex_lq_vld_1c, mvex_lq_id_1c, mvex_lq_data_1c,
      input  wb_vld, wb_vd, wb_data, wb_id,
      output wb_rdy
   );

   modport slave (
      input  alloc_vld, alloc_vd,
      output alloc_rdy, alloc_id,
      input  mvex_lq_vld_1c, mvex_lq_id_1c, mvex_lq_data_1c,
      output wb_vld, wb_vd, wb_data, wb_id,
      input  wb_rdy
   );

endinterface

// File: rtl/tt_mvex_lq_ptr.sv
// Wrap-around queue pointer. One extra MSB beyond the index bits lets the
// owner tell full from empty when head and tail indices coincide.
//   i_clk, i_reset_n  clock, async active-low reset (pointer -> 0)
//   i_inc             advance by one
//   i_clr             return to 0 (wins over i_inc)
//   o_ptr             current pointer
module tt_mvex_lq_ptr #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_ptr
);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)  o_ptr <= '0;
      else if (i_clr)  o_ptr <= '0;
      else if (i_inc)  o_ptr <= o_ptr + W'(1);
   end

endmodule

// File: rtl/tt_mvex_lq.sv
// Load queue for matrix-unit read results. Slots are allocated in order at
// issue, filled out of order by id, and drained in order to the VRF write port.
// Ports:
//   i_clk, i_reset_n   clock, async active-low reset
//   lq (slave)         alloc / fill / writeback handshakes
//   i_flush            discard all slots (priority over alloc, fill, drain)
//   o_count            occupied slots (0..DEPTH)
//   o_empty, o_full    count==0 / count==DEPTH
//   o_fill_err         sticky: a fill hit a slot that was not waiting for one
// Build option: TT_MVEX_LQ_BYPASS_EN lets a fill aimed at the waiting head
// slot appear on the writeback port in the same cycle.
//
// Per-slot state:
//   state     | meaning
//   LQ_FREE   | slot unused
//   LQ_ALLOC  | allocated, vd stored, waiting for its result
//   LQ_FILLED | result stored, waiting to drain
module tt_mvex_lq #(
   parameter int LQ_DEPTH_LOG2 = 3
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   tt_mvex_lq_if.slave            lq,
   input  logic                   i_flush,
   output logic [LQ_DEPTH_LOG2:0] o_count,
   output logic                   o_empty,
   output logic                   o_full,
   output logic                   o_fill_err
);
   import tt_mvex_lq_pkg::*;

   localparam int DEPTH = 2**LQ_DEPTH_LOG2;
   localparam int IW    = LQ_DEPTH_LOG2;
   localparam int PW    = LQ_DEPTH_LOG2 + 1;

   logic [PW-1:0]  head_q, tail_q;
   logic [IW-1:0]  head_idx, tail_idx;
   mvex_lq_state_e slot_st_q [DEPTH];
   mvex_lq_entry_t entry_q   [DEPTH];
   mvex_lq_state_e head_st, fill_st;
   logic           alloc_fire, fill_hit, fill_bad, bypass, wb_vld, drain_fire, data_we;

   assign head_idx = head_q[IW-1:0];
   assign tail_idx = tail_q[IW-1:0];
   assign head_st  = slot_st_q[head_idx];
   assign fill_st  = slot_st_q[lq.mvex_lq_id_1c];

   // Occupancy falls out of the pointer difference; the extra MSB keeps
   // DEPTH distinguishable from 0.
   assign o_count = tail_q - head_q;
   assign o_empty = (o_count == '0);
   assign o_full  = (o_count == PW'(DEPTH));

   assign lq.alloc_rdy = ~o_full;
   assign lq.alloc_id  = tail_idx;

   assign alloc_fire = lq.alloc_vld & ~o_full & ~i_flush;
   assign fill_hit   = lq.mvex_lq_vld_1c & ~i_flush & (fill_st == LQ_ALLOC);
   // A fill during flush is dropped too, and it breaks the "nothing in flight
   // at flush" promise, so it is flagged like any other stray fill.
   assign fill_bad   = lq.mvex_lq_vld_1c & (i_flush | (fill_st != LQ_ALLOC));

`ifdef TT_MVEX_LQ_BYPASS_EN
   // fill_hit already implies the target slot is ALLOC and no flush.
   assign bypass = fill_hit & (lq.mvex_lq_id_1c == head_idx);
`else
   assign bypass = 1'b0;
`endif

   assign wb_vld     = (head_st == LQ_FILLED) | bypass;
   assign drain_fire = wb_vld & lq.wb_rdy & ~i_flush;
   // A bypassed result that is accepted immediately never lands in the array.
   assign data_we    = fill_hit & ~(bypass & drain_fire);

   assign lq.wb_vld  = wb_vld;
   assign lq.wb_vd   = wb_vld ? entry_q[head_idx].vd : '0;
   assign lq.wb_id   = wb_vld ? head_idx : '0;
   assign lq.wb_data = !wb_vld ? '0 :
                       bypass  ? lq.mvex_lq_data_1c : entry_q[head_idx].data;

   tt_mvex_lq_ptr #(.W(PW)) u_head_ptr (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_inc     (drain_fire),
      .i_clr     (i_flush),
      .o_ptr     (head_q)
   );

   tt_mvex_lq_ptr #(.W(PW)) u_tail_ptr (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_inc     (alloc_fire),
      .i_clr     (i_flush),
      .o_ptr     (tail_q)
   );

   // Drain wins over fill on the same slot so an accepted bypass frees it.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < DEPTH; i++) slot_st_q[i] <= LQ_FREE;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_flush)                                      slot_st_q[i] <= LQ_FREE;
            else if (drain_fire && head_idx == IW'(i))        slot_st_q[i] <= LQ_FREE;
            else if (alloc_fire && tail_idx == IW'(i))        slot_st_q[i] <= LQ_ALLOC;
            else if (fill_hit && lq.mvex_lq_id_1c == IW'(i))  slot_st_q[i] <= LQ_FILLED;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (alloc_fire && tail_idx == IW'(i))          entry_q[i].vd   <= lq.alloc_vd;
         if (data_we && lq.mvex_lq_id_1c == IW'(i))     entry_q[i].data <= lq.mvex_lq_data_1c;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)    o_fill_err <= 1'b0;
      else if (fill_bad) o_fill_err <= 1'b1;
   end

endmodule

// File: tb/tb_tt_mvex_lq.sv
// Self-checking bench for tt_mvex_lq: directed scenarios followed by a random
// phase, all compared each cycle against an in-order queue model.
module tb_tt_mvex_lq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         a_vld, f_vld, wb_rdy, flush;
   logic [4:0]   a_vd;
   logic [2:0]   f_id;
   logic [255:0] f_data;
   logic [3:0]   count;
   logic         empty, full, fill_err;

   tt_mvex_lq_if #(.LQ_DEPTH_LOG2(3)) lq_if ();

   assign lq_if.alloc_vld       = a_vld;
   assign lq_if.alloc_vd        = a_vd;
   assign lq_if.mvex_lq_vld_1c  = f_vld;
   assign lq_if.mvex_lq_id_1c   = f_id;
   assign lq_if.mvex_lq_data_1c = f_data;
   assign lq_if.wb_rdy          = wb_rdy;

   tt_mvex_lq #(.LQ_DEPTH_LOG2(3)) dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n),
      .lq         (lq_if),
      .i_flush    (flush),
      .o_count    (count),
      .o_empty    (empty),
      .o_full     (full),
      .o_fill_err (fill_err)
   );

   typedef struct {
      int           id;
      logic [4:0]   vd;
      bit           filled;
      logic [255:0] data;
   } ent_t;

   ent_t mq[$];
   int   m_tail;
   bit   m_err;
   bit   e_vld;
   int   checks = 0;
   int   failures = 0;

`ifdef TT_MVEX_LQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rdata();
      logic [255:0] d;
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic set_idle();
      a_vld = 0; a_vd = '0; f_vld = 0; f_id = '0; f_data = '0; flush = 0; wb_rdy = 0;
   endtask

   task automatic check_outs(string tag);
      int           n;
      bit           hv, byp;
      logic [255:0] e_data;
      n   = mq.size();
      hv  = (n > 0) && mq[0].filled;
      byp = BYP && (n > 0) && !mq[0].filled && f_vld && !flush && (int'(f_id) == mq[0].id);
      e_vld  = hv | byp;
      e_data = hv ? mq[0].data : (byp ? f_data : '0);
      chk($sformatf("%s.count", tag),    count,              n);
      chk($sformatf("%s.empty", tag),    empty,              n == 0);
      chk($sformatf("%s.full", tag),     full,               n == 8);
      chk($sformatf("%s.alloc_rdy", tag), lq_if.alloc_rdy,   n < 8);
      chk($sformatf("%s.alloc_id", tag), lq_if.alloc_id,     m_tail);
      chk($sformatf("%s.wb_vld", tag),   lq_if.wb_vld,       e_vld);
      chk($sformatf("%s.wb_vd", tag),    lq_if.wb_vd,        e_vld ? mq[0].vd : 5'd0);
      chk($sformatf("%s.wb_id", tag),    lq_if.wb_id,        e_vld ? mq[0].id : 0);
      chk($sformatf("%s.wb_data", tag),  lq_if.wb_data,      e_data);
      chk($sformatf("%s.fill_err", tag), fill_err,           m_err);
   endtask

   task automatic update_model();
      int n0;
      bit found;
      if (flush) begin
         if (f_vld) m_err = 1;
         mq.delete();
         m_tail = 0;
      end else begin
         n0 = mq.size();
         if (f_vld) begin
            found = 0;
            foreach (mq[k]) if (mq[k].id == int'(f_id) && !mq[k].filled) begin
               mq[k].filled = 1; mq[k].data = f_data; found = 1;
            end
            if (!found) m_err = 1;
         end
         if (e_vld && wb_rdy) void'(mq.pop_front());
         if (a_vld && n0 < 8) begin
            mq.push_back('{id: m_tail, vd: a_vd, filled: 0, data: '0});
            m_tail = (m_tail + 1) % 8;
         end
      end
   endtask

   // Called right after a negedge with inputs already driven.
   task automatic cyc(string tag);
      #2;
      check_outs(tag);
      @(posedge clk);
      update_model();
      @(negedge clk);
   endtask

   task automatic do_reset(string tag);
      set_idle();
      rst_n = 0;
      mq.delete(); m_tail = 0; m_err = 0;
      #1;
      check_outs(tag);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic do_alloc(string tag, logic [4:0] vd);
      set_idle(); a_vld = 1; a_vd = vd;
      cyc(tag);
   endtask

   task automatic do_fill(string tag, int id, logic [255:0] d, logic rdy);
      set_idle(); f_vld = 1; f_id = 3'(id); f_data = d; wb_rdy = rdy;
      cyc(tag);
   endtask

   task automatic drain_all(string tag);
      int guard = 0;
      int unf[$];
      while (mq.size() > 0 && guard < 200) begin
         set_idle();
         unf.delete();
         foreach (mq[k]) if (!mq[k].filled) unf.push_back(mq[k].id);
         if (unf.size() > 0 && $urandom_range(0, 1) == 1) begin
            f_vld = 1; f_id = 3'(unf[$urandom_range(0, unf.size() - 1)]); f_data = rdata();
         end
         wb_rdy = 1'($urandom_range(0, 1));
         cyc(tag);
         guard++;
      end
      set_idle();
      chk($sformatf("%s.drained", tag), empty, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unf[$];
      set_idle();
      rst_n = 0;
      m_tail = 0; m_err = 0;
      @(negedge clk);
      do_reset("reset");
      cyc("reset_idle");

      // 1: out-of-order fill, in-order drain
      do_alloc("t1_alloc", 5'd3);
      do_alloc("t1_alloc", 5'd4);
      do_alloc("t1_alloc", 5'd5);
      do_fill("t1_fill1", 1, 256'hA, 1'b1);
      do_fill("t1_fill0", 0, 256'hB, 1'b1);
      do_fill("t1_fill2", 2, 256'hC, 1'b1);
      for (int i = 0; i < 4; i++) begin set_idle(); wb_rdy = 1; cyc("t1_drain"); end
      chk("t1_empty", empty, 1'b1);

      // 2: full queue refuses alloc even while draining
      for (int i = 0; i < 8; i++) do_alloc("t2_alloc", 5'($urandom));
      set_idle(); a_vld = 1; a_vd = 5'd9;
      cyc("t2_full_refuse");
      chk("t2_full", full, 1'b1);
      chk("t2_alloc_rdy", lq_if.alloc_rdy, 1'b0);
      chk("t2_count8", count, 4'd8);
      set_idle(); a_vld = 1; f_vld = 1; f_id = 3'(mq[0].id); f_data = rdata();
      cyc("t2_fill_head");
      set_idle(); a_vld = 1; wb_rdy = 1;
      cyc("t2_drain_no_alloc");
      chk("t2_count7", count, 4'd7);
      drain_all("t2_drain");

      // 3: stalled writeback keeps payload stable, one drain on rdy
      do_alloc("t3_alloc", 5'($urandom));
      do_alloc("t3_alloc", 5'($urandom));
      do_fill("t3_fill", mq[0].id, rdata(), 1'b0);
      do_fill("t3_fill", mq[1].id, rdata(), 1'b0);
      for (int i = 0; i < 5; i++) begin set_idle(); cyc("t3_stall"); end
      set_idle(); wb_rdy = 1; cyc("t3_accept");
      set_idle(); cyc("t3_after");
      chk("t3_count1", count, 4'd1);
      drain_all("t3_drain");

      // async reset while a writeback is on offer
      do_alloc("rst_mid_alloc", 5'd17);
      do_fill("rst_mid_fill", mq[0].id, rdata(), 1'b0);
      set_idle(); wb_rdy = 1;
      #2;
      rst_n = 0;
      #1;
      chk("rst_mid.count", count, 4'd0);
      chk("rst_mid.empty", empty, 1'b1);
      chk("rst_mid.full", full, 1'b0);
      chk("rst_mid.alloc_rdy", lq_if.alloc_rdy, 1'b1);
      chk("rst_mid.alloc_id", lq_if.alloc_id, 3'd0);
      chk("rst_mid.wb_vld", lq_if.wb_vld, 1'b0);
      chk("rst_mid.wb_vd", lq_if.wb_vd, 5'd0);
      chk("rst_mid.wb_id", lq_if.wb_id, 3'd0);
      chk("rst_mid.wb_data", lq_if.wb_data, 256'd0);
      chk("rst_mid.fill_err", fill_err, 1'b0);
      mq.delete(); m_tail = 0; m_err = 0;
      @(negedge clk);
      rst_n = 1;
      set_idle();

      // 4: ten alloc/drain pairs wrap the pointers back to index 2
      for (int i = 0; i < 10; i++) begin
         do_alloc("t4_alloc", 5'($urandom));
         do_fill("t4_fill", mq[0].id, rdata(), 1'b0);
         set_idle(); wb_rdy = 1; cyc("t4_drain");
      end
      chk("t4_empty", empty, 1'b1);
      chk("t4_alloc_id", lq_if.alloc_id, 3'd2);
      chk("t4_count", count, 4'd0);

      // 5: flush beats a same-cycle alloc; a later fill is flagged
      for (int i = 0; i < 3; i++) do_alloc("t5_alloc", 5'($urandom));
      for (int i = 0; i < 3; i++) do_fill("t5_fill", mq[2 - i].id, rdata(), 1'b0);
      set_idle(); flush = 1; a_vld = 1; a_vd = 5'd7;
      cyc("t5_flush");
      chk("t5_count", count, 4'd0);
      chk("t5_wb_vld", lq_if.wb_vld, 1'b0);
      do_fill("t5_stray_fill", 1, rdata(), 1'b0);
      set_idle(); cyc("t5_after");
      chk("t5_fill_err", fill_err, 1'b1);

      // 6: fill to the waiting head with rdy high
      do_reset("t6_reset");
      do_alloc("t6_alloc", 5'd11);
      set_idle(); f_vld = 1; f_id = 3'd0; f_data = 256'h55; wb_rdy = 1;
      #1;
      chk("t6_same_cycle_vld", lq_if.wb_vld, BYP);
      chk("t6_same_cycle_data", lq_if.wb_data, BYP ? 256'h55 : 256'h0);
      cyc("t6_fill");
      set_idle(); wb_rdy = 1;
      #1;
      chk("t6_next_cycle_vld", lq_if.wb_vld, !BYP);
      chk("t6_next_cycle_data", lq_if.wb_data, BYP ? 256'h0 : 256'h55);
      cyc("t6_next");
      chk("t6_empty", empty, 1'b1);

      // random mix of alloc / fill / drain / occasional flush
      for (int c = 0; c < 400; c++) begin
         set_idle();
         a_vld = 1'($urandom_range(0, 2) != 0);
         a_vd  = 5'($urandom);
         wb_rdy = 1'($urandom_range(0, 2) != 0);
         unf.delete();
         foreach (mq[k]) if (!mq[k].filled) unf.push_back(mq[k].id);
         if ($urandom_range(0, 49) == 0) begin
            flush = 1;
         end else if ($urandom_range(0, 29) == 0) begin
            f_vld = 1; f_id = 3'($urandom); f_data = rdata();
         end else if (unf.size() > 0 && $urandom_range(0, 1) == 1) begin
            f_vld = 1; f_id = 3'(unf[$urandom_range(0, unf.size() - 1)]); f_data = rdata();
         end
         cyc("rand");
      end
      drain_all("rand_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
